// File: rtl/mips_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mips_fetch_pkg
// Types and constants shared by the instruction fetch stage:
//   fetch_state_e : fetch FSM states (IDLE / REQ / DRAIN)
//   fetch_entry_t : one fetched entry {pc, instr, fault}
//   NOP_INSTR     : all-zero instruction word
//   word_align()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // no held request
        REQ   = 2'd1,  // imem_req high, waiting for imem_gnt
        DRAIN = 2'd2   // after a flush, discarding outstanding responses
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with a registered occupancy count. Storage is not reset;
// consumers must qualify dout_o with empty_o.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear_i         drop all contents (wins over push/pop in the same cycle)
//   push_i, din_i   write an entry (accepted when not full, or full and popping)
//   pop_i, dout_o   remove the head entry; dout_o shows the head
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries
// Parameters: WIDTH (entry bits), DEPTH (entries, power of two, >= 2)
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNTW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !clear_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// MIPS32 instruction fetch stage. Takes fetch addresses from the PC, issues
// word-aligned requests to instruction memory (req/gnt), pairs the in-order
// responses with their PCs and buffers up to DEPTH entries for decode.
// A flush discards everything buffered or in flight; responses still owed by
// memory are absorbed in the DRAIN state.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// (pc_valid/pc_ready, if_valid/if_ready, imem_req/imem_gnt) are both high.
// A requester keeps valid and its payload stable until the transfer.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pc_valid, pc, pc_ready     fetch address from the PC
//   flush                      redirect: drop buffered and in-flight fetches
//   imem_req, imem_addr,
//   imem_gnt                   memory request channel
//   imem_rvalid, imem_rdata    memory response channel (grant order)
//   if_valid, if_instr, if_pc,
//   if_fault, if_ready         decode channel
//   state_dbg                  current fetch FSM state
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : misaligned pc produces a fault entry instead of a memory access
//   undefined : pc[1:0] ignored for addressing, if_fault tied low
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pc_valid,
    input  logic [31:0]  pc,
    output logic         pc_ready,
    input  logic         flush,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic         if_valid,
    output logic [31:0]  if_instr,
    output logic [31:0]  if_pc,
    output logic         if_fault,
    input  logic         if_ready,
    output fetch_state_e state_dbg
);

    localparam int CW = $clog2(DEPTH) + 2;  // credit arithmetic width
    localparam int NW = $clog2(DEPTH) + 1;  // FIFO count width

    fetch_state_e  state_q;
    logic          imem_req_q;
    logic [31:0]   imem_addr_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] outst_d;

    logic [31:0]   pend_pc;
    logic          pend_full;
    logic          pend_empty;
    logic [NW-1:0] pend_count;

    fetch_entry_t  out_din;
    fetch_entry_t  out_head;
    logic          out_full;
    logic          out_empty;
    logic          out_push;
    logic          out_pop;
    logic [NW-1:0] out_count;

    logic [CW-1:0] credits;
    logic          base_ready;
    logic          misaligned;
    logic          accept;
    logic          issue;
    logic          gnt_fire;
    logic          resp;
    logic          resp_keep;
    logic          unused_sigs;

    // Every fetch owns a credit from acceptance until decode takes it (or a
    // flush drops it), so the output buffer can never overflow.
    always_comb begin
        credits    = outst_q + CW'(state_q == REQ) + CW'(out_count);
        base_ready = !rst && !flush && (state_q == IDLE) && (credits < CW'(DEPTH));
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // A fault entry bypasses memory, so it may only enter the buffer once
    // every earlier fetch has returned, keeping decode order intact.
    assign misaligned = (pc[1:0] != 2'b00);
    assign pc_ready   = base_ready && (!misaligned || (outst_q == '0));
`else
    assign misaligned = 1'b0;
    assign pc_ready   = base_ready;
`endif

    assign accept   = pc_valid && pc_ready;
    assign issue    = accept && !misaligned;
    // A grant in the flush cycle still counts: that response will arrive.
    assign gnt_fire = (state_q == REQ) && imem_gnt;
    // Responses with nothing outstanding (e.g. left over from before a reset)
    // are ignored.
    assign resp     = imem_rvalid && (outst_q != '0);
    assign resp_keep = resp && (state_q != DRAIN) && !flush && !pend_empty;
    assign outst_d  = outst_q + CW'(gnt_fire) - CW'(resp);

    always_comb begin
        out_din = '{pc: pend_pc, instr: imem_rdata, fault: 1'b0};
        if (accept && misaligned) begin
            out_din = '{pc: pc, instr: NOP_INSTR, fault: 1'b1};
        end
    end

    assign out_push = resp_keep || (accept && misaligned);
    assign out_pop  = if_valid && if_ready;

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pending_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (issue),
        .din_i   (pc),
        .pop_i   (resp_keep),
        .dout_o  (pend_pc),
        .full_o  (pend_full),
        .empty_o (pend_empty),
        .count_o (pend_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_out_buffer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .push_i  (out_push),
        .din_i   (out_din),
        .pop_i   (out_pop),
        .dout_o  (out_head),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_count)
    );

    // Fetch FSM with registered request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            outst_q     <= '0;
        end else begin
            outst_q <= outst_d;
            if (flush) begin
                imem_req_q <= 1'b0;
                state_q    <= (outst_d != '0) ? DRAIN : IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (issue) begin
                            imem_addr_q <= word_align(pc);
                            imem_req_q  <= 1'b1;
                            state_q     <= REQ;
                        end
                    end
                    REQ: begin
                        if (imem_gnt) begin
                            imem_req_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (outst_d == '0) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        imem_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign state_dbg = state_q;

    // Decode-side outputs read zero whenever the buffer is empty.
    assign if_valid = !out_empty;
    assign if_instr = out_empty ? NOP_INSTR : out_head.instr;
    assign if_pc    = out_empty ? 32'h0 : out_head.pc;
`ifdef FETCH_ALIGN_CHECK_EN
    assign if_fault = !out_empty && out_head.fault;
`else
    assign if_fault = 1'b0;
`endif

    assign unused_sigs = &{1'b0, pend_full, pend_count, out_full, out_head.fault};

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import mips_fetch_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic         clk;
  logic         rst;
  logic         pc_valid;
  logic [31:0]  pc;
  logic         pc_ready;
  logic         flush;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic         if_valid;
  logic [31:0]  if_instr;
  logic [31:0]  if_pc;
  logic         if_fault;
  logic         if_ready;
  fetch_state_e state_dbg;

  instr_fetch_unit #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_valid    (pc_valid),
    .pc          (pc),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_fault    (if_fault),
    .if_ready    (if_ready),
    .state_dbg   (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int fails     = 0;
  logic [64:0] exp_q[$];   // {pc, instr, fault}

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] ent(input logic [31:0] p, input logic [31:0] i, input logic f);
    return {p, i, f};
  endfunction

  // ---------------- memory responder ----------------
  typedef struct {
    logic [31:0] addr;
    int          gcyc;
  } mreq_t;

  mreq_t mq[$];
  bit    mem_en    = 1'b1;
  bit    resp_hold = 1'b0;
  int    gnt_delay = 0;
  int    req_wait  = 0;
  int    grants    = 0;

  // Grants after gnt_delay waiting cycles; responds one or more cycles after grant.
  // Read data = 0x2008_0001 + word index.
  initial forever begin
    mreq_t m;
    @(negedge clk);
    if (mem_en) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (rst) begin
        mq.delete();
        req_wait = 0;
      end else begin
        if (!resp_hold && mq.size() > 0 && mq[0].gcyc < cyc) begin
          m = mq.pop_front();
          imem_rvalid = 1'b1;
          imem_rdata  = 32'h2008_0001 + (m.addr >> 2);
        end
        if (imem_req) begin
          if (req_wait >= gnt_delay) begin
            imem_gnt = 1'b1;
            m.addr   = imem_addr;
            m.gcyc   = cyc;
            mq.push_back(m);
            req_wait = 0;
            grants++;
          end else begin
            req_wait++;
          end
        end else begin
          req_wait = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [64:0] e;
    @(negedge clk);
    #2;
    if (!rst && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $display("FAIL unexpected_output: got pc=%h instr=%h fault=%b, required no output",
                 if_pc, if_instr, if_fault);
      end else begin
        e = exp_q.pop_front();
        check("if_entry", {if_pc, if_instr, if_fault}, e);
      end
    end
  end

  // ---------------- driver ----------------
  int acc_cyc;

  // Call during the low clock phase. Returns on the negedge after acceptance.
  task automatic send_pc(input logic [31:0] a, input logic [64:0] e, input bit expect_out);
    int guard = 0;
    pc       = a;
    pc_valid = 1'b1;
    #1;
    while (!pc_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!pc_ready) begin
      tests_run++;
      fails++;
      $display("FAIL pc_accept_timeout: got pc_ready=0 for pc %h, required acceptance", a);
    end else begin
      if (expect_out) exp_q.push_back(e);
      acc_cyc = cyc;
    end
    @(negedge clk);
    pc_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited;
    rst         = 1'b1;
    pc_valid    = 1'b0;
    pc          = '0;
    flush       = 1'b0;
    if_ready    = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_imem_req",  imem_req,  0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_if_valid",  if_valid,  0);
    check("rst_if_instr",  if_instr,  0);
    check("rst_if_pc",     if_pc,     0);
    check("rst_if_fault",  if_fault,  0);
    check("rst_state",     state_dbg, IDLE);
    check("rst_pc_ready",  pc_ready,  0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_pc_ready", pc_ready, 1);

    // In-order fetch with single-cycle grant/response and first-valid latency
    send_pc(32'h0000_0000, ent(32'h0000_0000, 32'h2008_0001, 1'b0), 1'b1);
    #1;
    check("req_next_cycle", imem_req, 1);
    check("req_addr_0", imem_addr, 32'h0000_0000);
    waited = 0;
    while (!if_valid && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("first_valid_latency", cyc - acc_cyc, 3);
    send_pc(32'h0000_0004, ent(32'h0000_0004, 32'h2008_0002, 1'b0), 1'b1);
    send_pc(32'h0000_0008, ent(32'h0000_0008, 32'h2008_0003, 1'b0), 1'b1);
    idle_cycles(8);

    // Decode backpressure: credits run out at DEPTH, nothing lost
    if_ready = 1'b0;
    send_pc(32'h0000_0100, ent(32'h0000_0100, 32'h2008_0041, 1'b0), 1'b1);
    send_pc(32'h0000_0104, ent(32'h0000_0104, 32'h2008_0042, 1'b0), 1'b1);
    idle_cycles(6);
    pc       = 32'h0000_0108;
    pc_valid = 1'b1;
    #1;
    check("bp_pc_ready_low", pc_ready, 0);
    check("bp_if_valid", if_valid, 1);
    check("bp_head_pc", if_pc, 32'h0000_0100);
    @(negedge clk);
    if_ready = 1'b1;
    send_pc(32'h0000_0108, ent(32'h0000_0108, 32'h2008_0043, 1'b0), 1'b1);
    idle_cycles(8);

    // Grant delayed by 4 cycles: request held stable, one grant
    gnt_delay = 4;
    waited = grants;
    send_pc(32'h0000_0010, ent(32'h0000_0010, 32'h2008_0005, 1'b0), 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("held_req", imem_req, 1);
      check("held_addr", imem_addr, 32'h0000_0010);
      @(negedge clk);
    end
    idle_cycles(6);
    check("single_grant", grants - waited, 1);
    check("req_dropped", imem_req, 0);
    gnt_delay = 0;

    // Flush with two outstanding fetches
    resp_hold = 1'b1;
    send_pc(32'h0000_0200, '0, 1'b0);
    send_pc(32'h0000_0204, '0, 1'b0);
    idle_cycles(2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_state_drain", state_dbg, DRAIN);
    check("flush_if_valid", if_valid, 0);
    check("drain_pc_ready", pc_ready, 0);
    resp_hold = 1'b0;
    waited = 0;
    while (state_dbg != IDLE && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("drain_done_state", state_dbg, IDLE);
    check("drain_if_valid", if_valid, 0);
    check("drain_pc_ready_back", pc_ready, 1);
    send_pc(32'h0040_0000, ent(32'h0040_0000, 32'h2018_0001, 1'b0), 1'b1);
    idle_cycles(8);

    // Misaligned pc
`ifdef FETCH_ALIGN_CHECK_EN
    send_pc(32'h0000_0006, ent(32'h0000_0006, 32'h0000_0000, 1'b1), 1'b1);
    #1;
    check("misalign_no_req", imem_req, 0);
`else
    send_pc(32'h0000_0006, ent(32'h0000_0006, 32'h2008_0002, 1'b0), 1'b1);
    #1;
    check("misalign_req", imem_req, 1);
    check("misalign_addr", imem_addr, 32'h0000_0004);
`endif
    idle_cycles(8);

    // Reset while a request is held; stray rvalid afterwards is ignored
    gnt_delay = 10;
    send_pc(32'h0000_0300, '0, 1'b0);
    #1;
    check("pre_rst_state_req", state_dbg, REQ);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_imem_req", imem_req, 0);
    check("midrst_if_valid", if_valid, 0);
    check("midrst_imem_addr", imem_addr, 0);
    check("midrst_state", state_dbg, IDLE);
    rst       = 1'b0;
    gnt_delay = 0;
    mem_en    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stray_rvalid_ignored", if_valid, 0);
      @(negedge clk);
    end
    mem_en = 1'b1;
    send_pc(32'h0000_0020, ent(32'h0000_0020, 32'h2008_0009, 1'b0), 1'b1);
    idle_cycles(8);

    // Final report
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
